// File: rtl/mul_fu_pkg.sv
// rtl/mul_fu_pkg.sv - shared RV32M multiply op encodings, FU index and latency
package mul_fu_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  localparam int FU_MUL      = 3;
  localparam int MUL_LATENCY = 7;

  function automatic logic rs1_signed(input logic [1:0] op);
    return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
  endfunction

  function automatic logic rs2_signed(input logic [1:0] op);
    return op == MUL_OP_MULH;
  endfunction

endpackage

// File: rtl/mul_fu_if.sv
// rtl/mul_fu_if.sv - issue/result bundle between the issue stage and the multiply unit
interface mul_fu_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic [WIDTH-1:0] res;
  logic             res_valid;
  logic             busy;

  modport master (
    output en, op, rs1_data, rs2_data,
    input  res, res_valid, busy
  );

  modport slave (
    input  en, op, rs1_data, rs2_data,
    output res, res_valid, busy
  );
endinterface

// File: rtl/mul_acc_stage.sv
// rtl/mul_acc_stage.sv - one accumulate stage: adds G partial products into the running sum
module mul_acc_stage #(
  parameter int WIDTH = 32,
  parameter int IDX   = 0,
  parameter int G     = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [1:0]           op_i,
  input  logic [WIDTH:0]       mcand_i,
  input  logic [WIDTH:0]       mplier_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  output logic                 valid_o,
  output logic [1:0]           op_o,
  output logic [WIDTH:0]       mcand_o,
  output logic [WIDTH:0]       mplier_o,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [2*WIDTH-1:0] mcand_ext;
  logic [2*WIDTH-1:0] psum [0:G];

  assign mcand_ext = {{(WIDTH-1){mcand_i[WIDTH]}}, mcand_i};
  assign psum[0]   = acc_i;

  // Multiplier bit WIDTH carries negative weight; bits beyond it contribute nothing.
  for (genvar i = 0; i < G; i++) begin : g_pp
    localparam int B = IDX * G + i;
    if (B < WIDTH) begin : g_add
      assign psum[i+1] = mplier_i[B] ? psum[i] + (mcand_ext << B) : psum[i];
    end else if (B == WIDTH) begin : g_sub
      assign psum[i+1] = mplier_i[B] ? psum[i] - (mcand_ext << B) : psum[i];
    end else begin : g_zero
      assign psum[i+1] = psum[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o  <= 1'b0;
      op_o     <= '0;
      mcand_o  <= '0;
      mplier_o <= '0;
      acc_o    <= '0;
    end else begin
      valid_o  <= valid_i;
      op_o     <= op_i;
      mcand_o  <= mcand_i;
      mplier_o <= mplier_i;
      acc_o    <= psum[G];
    end
  end

endmodule

// File: rtl/mul_fu.sv
// rtl/mul_fu.sv - pipelined RV32M multiply unit (MUL/MULH/MULHSU/MULHU)
module mul_fu
  import mul_fu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = MUL_LATENCY
) (
  input  logic     clk,
  input  logic     rst,
  mul_fu_if.slave  bus
);

  localparam int N  = LATENCY - 2;
  localparam int G  = (WIDTH + N) / N;
  localparam int AW = 2 * WIDTH;

  logic           v1_q;
  logic [1:0]     op1_q;
  logic [WIDTH:0] a1_q, b1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q  <= 1'b0;
      op1_q <= '0;
      a1_q  <= '0;
      b1_q  <= '0;
    end else begin
      v1_q <= bus.en;
      if (bus.en) begin
        op1_q <= bus.op;
        a1_q  <= {rs1_signed(bus.op) & bus.rs1_data[WIDTH-1], bus.rs1_data};
        b1_q  <= {rs2_signed(bus.op) & bus.rs2_data[WIDTH-1], bus.rs2_data};
      end
    end
  end

  logic [N:0]                valid_s;
  logic [N:0][1:0]           op_s;
  logic [N:0][WIDTH:0]       mcand_s, mplier_s;
  logic [N:0][AW-1:0]        acc_s;

  assign valid_s[0]  = v1_q;
  assign op_s[0]     = op1_q;
  assign mcand_s[0]  = a1_q;
  assign mplier_s[0] = b1_q;
  assign acc_s[0]    = '0;

  for (genvar k = 0; k < N; k++) begin : g_stage
    mul_acc_stage #(.WIDTH(WIDTH), .IDX(k), .G(G)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .valid_i  (valid_s[k]),
      .op_i     (op_s[k]),
      .mcand_i  (mcand_s[k]),
      .mplier_i (mplier_s[k]),
      .acc_i    (acc_s[k]),
      .valid_o  (valid_s[k+1]),
      .op_o     (op_s[k+1]),
      .mcand_o  (mcand_s[k+1]),
      .mplier_o (mplier_s[k+1]),
      .acc_o    (acc_s[k+1])
    );
  end

  // Half-select is registered ahead of res so the result lands exactly LATENCY edges after issue.
  logic             sel_v_q, res_valid_q;
  logic [WIDTH-1:0] sel_q, res_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_v_q     <= 1'b0;
      sel_q       <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      sel_v_q     <= valid_s[N];
      res_valid_q <= sel_v_q;
      if (valid_s[N]) begin
        sel_q <= (op_s[N] == MUL_OP_MUL) ? acc_s[N][WIDTH-1:0] : acc_s[N][AW-1:WIDTH];
      end
      if (sel_v_q) begin
        res_q <= sel_q;
      end
    end
  end

  assign bus.res       = res_q;
  assign bus.res_valid = res_valid_q;
  assign bus.busy      = (|valid_s) | sel_v_q;

  logic unused_tail;
  assign unused_tail = ^{mcand_s[N], mplier_s[N]};

endmodule

// File: doc/mul_fu.md
# mul_fu

Pipelined RV32M multiply functional unit (FU #3) for MUL, MULH, MULHSU and MULHU.
- The control unit issues to it through its MUL enable. It expects the result exactly LATENCY cycles later, when the unit's slot reaches reservation entry 0.
- The unit sits between the ID/issue stage (operand read) and the writeback mux, which selects it when write_sel = 3.
- It is fully pipelined and accepts one operation per cycle. The scoreboard currently issues at most one operation at a time.

## Interface
Parameters:
- WIDTH, 32, operand and result width.
- LATENCY, 7, cycles from issue edge to result edge. Legal range is 3..16. The value must equal the control unit's MUL delay entry.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset, asynchronous, active-high.
- en, input, 1, issue strobe. This is the control unit's MUL enable, already gated by hazard and flush.
- op, input, 2, operation select = funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- rs1_data, input, WIDTH, multiplicand.
- rs2_data, input, WIDTH, multiplier.
- res, output, WIDTH, registered result.
- res_valid, output, 1, one-cycle pulse marking a new result on res.
- busy, output, 1, OR of all stage-valid bits, excluding the output register.

## Operation
- **Sign handling:** each operand is extended to WIDTH+1 bits.
  - rs1 is sign-extended for MULH and MULHSU, zero-extended otherwise.
  - rs2 is sign-extended for MULH only.
  - MUL may use either extension, because the low half is identical.
- **Product:** the signed (WIDTH+1)×(WIDTH+1) product is formed. Only the low 2·WIDTH bits are kept.
  - MUL returns bits [WIDTH-1:0].
  - All other ops return bits [2·WIDTH-1:WIDTH].
- **Stage S1 (capture):** on an edge with en=1, capture the extended operands and op, and set v1=1. With en=0, set v1=0; the operand registers may hold stale data.
- **Stages S2..S(LATENCY-1) (accumulate):** there are N = LATENCY-2 accumulate stages. Let G = ceil((WIDTH+1)/N).
  - Stage j adds the partial products for multiplier bits [(j-2)·G, (j-1)·G-1] into a 2·WIDTH-bit accumulator.
  - Bits at or above WIDTH+1 are treated as zero.
  - The partial product for multiplier bit WIDTH (the sign bit) is subtracted, not added (two's-complement weight).
  - Each stage forwards multiplicand, remaining multiplier bits, op and its valid bit.
  - All arithmetic is modulo 2^(2·WIDTH).
- **Stage S(LATENCY) (select):** when the valid bit is set, load res with the half chosen by op and pulse res_valid for one cycle.
  - When the valid bit is clear, res holds its previous value and res_valid=0.
- **Independence:** valid bits advance every cycle; there is no stall input. Back-to-back operations do not interact.
- **No kill input:** flush is handled upstream. An op accepted by en always completes.

## Timing
- **Latency:** en sampled high at edge k gives res/res_valid updated at edge k+LATENCY. With LATENCY=7, issue at edge 0 gives the result visible after edge 7.
- **Writeback:** the control unit registers write_sel=3 at that same edge, so the writeback mux reads res while res_valid=1.
- **Throughput:** one result per cycle for consecutive en cycles.
- **Reset values:** all valid bits 0, busy=0, res=0, res_valid=0, accumulators 0.
- **Reset mid-operation:** every in-flight op is discarded. No res_valid pulse occurs for ops issued before reset deassertion.
- **en on the first edge after reset deassertion:** accepted normally.
- **Operand timing:** op/rs1/rs2 must be stable only at the edge where en=1. They are don't-care otherwise.
- **res stability:** res is stable from one res_valid pulse until the next.

## Structure
- **Shared package:** holds the op encodings (MUL_OP_MUL/MULH/MULHSU/MULHU) and the FU index constant FU_MUL=3.
  - It also holds the latency constant MUL_LATENCY=7, consumed by both this unit and the control unit's delay table.
- **Sub-module mul_acc_stage:** one accumulate stage, parameterised by stage index and G, instantiated N times in a generate loop.
  - Inputs: valid, op, multiplicand, multiplier slice, accumulator.
  - Registered outputs: the same signals, updated.

## Test plan
- **MUL:** MUL 7×6 issued at edge 0 → res=0x0000002A with res_valid high only after edge 7; busy high edges 1–6.
- **MULH:** MULH 0x80000000×0x80000000 → res=0x40000000. MULH 0xFFFFFFFF×0x00000002 → res=0xFFFFFFFF.
- **MULHSU:** MULHSU 0xFFFFFFFF×0xFFFFFFFF → res=0xFFFFFFFF.
- **MULHU / MUL low half:** MULHU 0xFFFFFFFF×0xFFFFFFFF → res=0xFFFFFFFE. MUL on the same operands → res=0x00000001.
- **Back-to-back:** en high edges 0,1,2 with MUL 3×3, MULHU 0xFFFFFFFF×0xFFFFFFFF, MUL 5×5 → pulses after edges 7,8,9 with res=9, 0xFFFFFFFE, 25 in order.
- **Reset mid-flight:** issue at edge 0, assert rst between edges 3 and 4 → res=0, res_valid never pulses, busy=0. A new MUL 2×2 issued after release yields 4 exactly LATENCY edges later.
